// File: rtl/deser_pkg.sv
// Shared types and constants for the 4-bit serial-to-parallel deserializer.
package deser_pkg;

  localparam int WORD_BITS = 4;
  localparam int CNT_W     = $clog2(WORD_BITS);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // Shift-register slot for the bit arriving at position cnt of the word.
  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] cnt,
                                               input logic             msb_first);
    return msb_first ? (CNT_W'(WORD_BITS - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/deser_4b_ctrl.sv
// Two-state word-assembly FSM with bit counter; flags the transfer that completes a word.
module deser_4b_ctrl
  import deser_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_xfer,
  input  logic             out_rdy,
  output state_e           state,
  output logic [CNT_W-1:0] count,
  output logic             load
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      COLLECT: begin
        if (in_xfer) begin
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(WORD_BITS - 1)) state_d = FULL;
        end
      end
      FULL: begin
        // A bit accepted alongside the drain becomes bit 0 of the next word.
        if (out_rdy) begin
          state_d = COLLECT;
          count_d = in_xfer ? CNT_W'(1) : '0;
        end
      end
      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    load = (state_q == COLLECT) && in_xfer && (count_q == CNT_W'(WORD_BITS - 1));
  end

  assign state = state_q;
  assign count = count_q;

endmodule

// File: rtl/deser_4b.sv
// Serial-in, 4-bit parallel-out deserializer with valid/ready handshakes on both sides.
module deser_4b
  import deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  input  logic                 in_bit,
  output logic                 in_rdy,
  output logic                 out_val,
  output logic [WORD_BITS-1:0] out_data,
  input  logic                 out_rdy
);

  state_e               state;
  logic [CNT_W-1:0]     count;
  logic                 load;
  logic                 rdy_int;
  logic                 in_xfer;
  logic [CNT_W-1:0]     wr_pos;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [WORD_BITS-1:0] data_q, data_d;

  // Flops are already held by the async reset, so only the visible ready is gated.
  assign rdy_int = (state == COLLECT) || out_rdy;
  assign in_rdy  = reset && rdy_int;
  assign in_xfer = in_val && rdy_int;
  assign out_val = (state == FULL);
  assign wr_pos  = bit_pos(count, MSB_FIRST);

  deser_4b_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .in_xfer (in_xfer),
    .out_rdy (out_rdy),
    .state   (state),
    .count   (count),
    .load    (load)
  );

  always_comb begin
    shreg_d = shreg_q;
    if (in_xfer) shreg_d[wr_pos] = in_bit;
    data_d = load ? shreg_d : data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      data_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      data_q  <= data_d;
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_deser_4b.sv
// Self-checking bench for deser_4b: directed scenarios plus randomized run against a queue model.
module tb_deser_4b;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_val = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_rdy = 1'b0;
  logic       in_rdy0, out_val0, in_rdy1, out_val1;
  logic [3:0] out_data0, out_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deser_4b #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_bit(in_bit),
    .in_rdy(in_rdy0), .out_val(out_val0), .out_data(out_data0), .out_rdy(out_rdy)
  );

  deser_4b #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_bit(in_bit),
    .in_rdy(in_rdy1), .out_val(out_val1), .out_data(out_data1), .out_rdy(out_rdy)
  );

  // Reference model: bits of the current word in arrival order, plus the presented word.
  bit         mq[$];
  bit         m_full;
  logic [3:0] m_word0, m_word1;

  always @(posedge clk or negedge reset) begin
    bit in_x, out_x;
    if (!reset) begin
      mq.delete();
      m_full  = 1'b0;
      m_word0 = 4'b0000;
      m_word1 = 4'b0000;
    end else begin
      out_x = m_full && out_rdy;
      in_x  = in_val && (m_full ? out_rdy : 1'b1);
      if (out_x) m_full = 1'b0;
      if (in_x) begin
        mq.push_back(in_bit);
        if (mq.size() == 4) begin
          for (int i = 0; i < 4; i++) begin
            m_word0[i]     = mq[i];
            m_word1[3 - i] = mq[i];
          end
          m_full = 1'b1;
          mq.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_val = 1'b1;
    in_bit = b;
    step();
  endtask

  task automatic drain();
    in_val  = 1'b0;
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_rdy = 1'b0; in_val = 1'b1; in_bit = 1'b1;
    #2;
    checks++; if (out_val0 !== 1'b0) begin errors++; $display("FAIL rst_init_out_val act=%b exp=0", out_val0); end
    checks++; if (in_rdy0 !== 1'b0) begin errors++; $display("FAIL rst_init_in_rdy act=%b exp=0", in_rdy0); end
    step(); step();
    checks++; if (out_data0 !== 4'b0000) begin errors++; $display("FAIL rst_held_no_xfer act=%b exp=0000", out_data0); end
    reset = 1'b1;
    #1;
    checks++; if (in_rdy0 !== 1'b1) begin errors++; $display("FAIL rst_release_in_rdy act=%b exp=1", in_rdy0); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    in_val = 1'b0;
    checks++; if (out_val0 !== 1'b1) begin errors++; $display("FAIL rst_pre_full act=%b exp=1", out_val0); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_val0 !== 1'b0) begin errors++; $display("FAIL rst_async_out_val act=%b exp=0", out_val0); end
    checks++; if (out_data0 !== 4'b0000) begin errors++; $display("FAIL rst_async_data0 act=%b exp=0000", out_data0); end
    checks++; if (out_data1 !== 4'b0000) begin errors++; $display("FAIL rst_async_data1 act=%b exp=0000", out_data1); end
    checks++; if (in_rdy0 !== 1'b0) begin errors++; $display("FAIL rst_async_in_rdy act=%b exp=0", in_rdy0); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_lsb_first();
    out_rdy = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (out_val0 !== 1'b0) begin errors++; $display("FAIL lsb_partial_out_val act=%b exp=0", out_val0); end
    checks++; if (in_rdy0 !== 1'b1) begin errors++; $display("FAIL lsb_partial_in_rdy act=%b exp=1", in_rdy0); end
    send_bit(1'b1);
    checks++; if (out_val0 !== 1'b1) begin errors++; $display("FAIL lsb_out_val act=%b exp=1", out_val0); end
    checks++; if (out_data0 !== 4'b1101) begin errors++; $display("FAIL lsb_out_data act=%b exp=1101", out_data0); end
    checks++; if (out_data1 !== 4'b1011) begin errors++; $display("FAIL msb_out_data act=%b exp=1011", out_data1); end
    checks++; if (in_rdy0 !== 1'b0) begin errors++; $display("FAIL lsb_full_in_rdy act=%b exp=0", in_rdy0); end
    checks++; if (in_rdy1 !== 1'b0) begin errors++; $display("FAIL msb_full_in_rdy act=%b exp=0", in_rdy1); end
    send_bit(1'b0); send_bit(1'b0);
    checks++; if (out_data0 !== 4'b1101) begin errors++; $display("FAIL lsb_hold_data act=%b exp=1101", out_data0); end
    drain();
    checks++; if (out_val0 !== 1'b0) begin errors++; $display("FAIL lsb_drain_out_val act=%b exp=0", out_val0); end
    checks++; if (out_data0 !== 4'b1101) begin errors++; $display("FAIL lsb_drain_keeps_data act=%b exp=1101", out_data0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    logic [3:0] exp_w;
    bits = 8'b1001_0110;  // bits[0] goes first: 0,1,1,0,1,0,0,1
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_in_rdy[%0d] act=%b exp=1", i, in_rdy0); end
      send_bit(bits[i]);
      checks++;
      if (out_val0 !== ((i % 4) == 3)) begin
        errors++; $display("FAIL b2b_out_val[%0d] act=%b exp=%b", i, out_val0, ((i % 4) == 3));
      end
      if ((i % 4) == 3) begin
        exp_w = (i == 3) ? 4'b0110 : 4'b1001;
        checks++; if (out_data0 !== exp_w) begin errors++; $display("FAIL b2b_word[%0d] act=%b exp=%b", i, out_data0, exp_w); end
        $display("b2b word %0d: %b", i / 4, out_data0);
      end
    end
    in_val = 1'b0;
    step();
    checks++; if (out_val0 !== 1'b0) begin errors++; $display("FAIL b2b_final_drain act=%b exp=0", out_val0); end
    out_rdy = 1'b0;
  endtask

  task automatic test_stall();
    out_rdy = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1;
      in_bit = 1'($urandom);
      step();
      checks++; if (out_data0 !== 4'b1111) begin errors++; $display("FAIL stall_data[%0d] act=%b exp=1111", i, out_data0); end
      checks++; if (out_val0 !== 1'b1) begin errors++; $display("FAIL stall_out_val[%0d] act=%b exp=1", i, out_val0); end
      checks++; if (in_rdy0 !== 1'b0) begin errors++; $display("FAIL stall_in_rdy[%0d] act=%b exp=0", i, in_rdy0); end
    end
    out_rdy = 1'b1;
    #1;
    checks++; if (in_rdy0 !== 1'b1) begin errors++; $display("FAIL stall_passthru_rdy act=%b exp=1", in_rdy0); end
    send_bit(1'b0);
    checks++; if (out_val0 !== 1'b0) begin errors++; $display("FAIL stall_release_out_val act=%b exp=0", out_val0); end
    out_rdy = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    in_val = 1'b0;
    checks++; if (out_val0 !== 1'b1) begin errors++; $display("FAIL stall_next_out_val act=%b exp=1", out_val0); end
    checks++; if (out_data0 !== 4'b1110) begin errors++; $display("FAIL stall_next_data0 act=%b exp=1110", out_data0); end
    checks++; if (out_data1 !== 4'b0111) begin errors++; $display("FAIL stall_next_data1 act=%b exp=0111", out_data1); end
    drain();
  endtask

  task automatic test_midword_reset();
    out_rdy = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    in_val = 1'b1; in_bit = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (in_rdy0 !== 1'b0) begin errors++; $display("FAIL mid_rst_in_rdy act=%b exp=0", in_rdy0); end
    step();
    reset = 1'b1;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    in_val = 1'b0;
    checks++; if (out_val0 !== 1'b1) begin errors++; $display("FAIL mid_rst_out_val act=%b exp=1", out_val0); end
    checks++; if (out_data0 !== 4'b1000) begin errors++; $display("FAIL mid_rst_data0 act=%b exp=1000", out_data0); end
    checks++; if (out_data1 !== 4'b0001) begin errors++; $display("FAIL mid_rst_data1 act=%b exp=0001", out_data1); end
    drain();
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int n = 0; n < 400; n++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      in_bit  = 1'($urandom);
      out_rdy = ($urandom_range(0, 2) != 0);
      reset   = ($urandom_range(0, 63) != 0);
      #1;
      exp_rdy = reset && (!m_full || out_rdy);
      checks++; if (out_val0 !== m_full) begin errors++; $display("FAIL rnd_out_val0[%0d] act=%b exp=%b", n, out_val0, m_full); end
      checks++; if (out_val1 !== m_full) begin errors++; $display("FAIL rnd_out_val1[%0d] act=%b exp=%b", n, out_val1, m_full); end
      checks++; if (out_data0 !== m_word0) begin errors++; $display("FAIL rnd_data0[%0d] act=%b exp=%b", n, out_data0, m_word0); end
      checks++; if (out_data1 !== m_word1) begin errors++; $display("FAIL rnd_data1[%0d] act=%b exp=%b", n, out_data1, m_word1); end
      checks++; if (in_rdy0 !== exp_rdy) begin errors++; $display("FAIL rnd_in_rdy[%0d] act=%b exp=%b", n, in_rdy0, exp_rdy); end
      if (reset && out_val0 && out_rdy) $display("rnd word out: lsb=%b msb=%b", out_data0, out_data1);
      step();
    end
    reset = 1'b1;
    in_val = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_midword_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
